// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage and its control slice.
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  // Sequencer FSM encoding, kept as plain 2-bit constants for legacy tools.
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_RUN      = 2'd0;
  localparam fsm_state_t ST_LU_STALL = 2'd1;
  localparam fsm_state_t ST_HALT     = 2'd2;
  localparam fsm_state_t ST_STEP     = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: merges redirect, load-use, memory-busy and debug
// requests into stall/flush/redirect controls, and counts stall/flush events.
module fetch_sequencer #(
  parameter int PC_W        = fetch_pkg::PC_W,
  parameter int FLUSH_EXTRA = 1,
  parameter int LU_STALL    = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_addr,
  input  logic             load_use,
  input  logic             mem_busy,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             step,
  output logic             stall,
  output logic             flush,
  output logic             PC_sel,
  output logic [PC_W-1:0]  branch_target,
  output logic             flush_id,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import fetch_pkg::*;

  localparam logic [2:0] LU_INIT = 3'(LU_STALL - 1);
  localparam logic [1:0] FL_INIT = 2'(FLUSH_EXTRA);

  fsm_state_t state, state_nxt;
  // lu_cnt = load-use stall cycles still owed after the current one.
  logic [2:0] lu_cnt, lu_cnt_nxt;
  logic [1:0] fl_cnt, fl_cnt_nxt;

  // A redirect never stalls: the wrong-path work is squashed instead.
  always_comb begin
    // NOTE: default assignment first so no path leaves stall unassigned
    // (which would infer a latch).
    stall = 1'b0;
    if (branch_taken) begin
      stall = 1'b0;
    end else if (mem_busy) begin
      stall = 1'b1;
    end else begin
      case (state)
        ST_RUN:      stall = load_use;
        ST_LU_STALL: stall = 1'b1;
        ST_HALT:     stall = 1'b1;
        default:     stall = 1'b0;
      endcase
    end
  end

  assign PC_sel        = branch_taken;
  assign flush         = branch_taken;
  assign branch_target = branch_taken ? branch_addr : '0;
  assign flush_id      = branch_taken | (fl_cnt != 2'd0);
  assign halted        = (state == ST_HALT);

  always_comb begin
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    fl_cnt_nxt = (fl_cnt != 2'd0) ? fl_cnt - 2'd1 : 2'd0;

    if (branch_taken) begin
      fl_cnt_nxt = FL_INIT;
      lu_cnt_nxt = 3'd0;
      case (state)
        ST_LU_STALL: state_nxt = ST_RUN;
        ST_STEP:     state_nxt = ST_HALT;
        default:     state_nxt = state;
      endcase
    end else if (!mem_busy) begin
      case (state)
        ST_RUN: begin
          if (halt_req) begin
            state_nxt = ST_HALT;
          end else if (load_use) begin
            // A single-cycle stall is fully served in this RUN cycle.
            lu_cnt_nxt = LU_INIT;
            if (LU_INIT != 3'd0) state_nxt = ST_LU_STALL;
          end
        end
        ST_LU_STALL: begin
          if (halt_req) begin
            state_nxt  = ST_HALT;
            lu_cnt_nxt = 3'd0;
          end else begin
            lu_cnt_nxt = lu_cnt - 3'd1;
            if (lu_cnt == 3'd1) state_nxt = ST_RUN;
          end
        end
        ST_HALT: begin
          if (resume)    state_nxt = ST_RUN;
          else if (step) state_nxt = ST_STEP;
        end
        default: state_nxt = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      lu_cnt <= 3'd0;
      fl_cnt <= 2'd0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
      fl_cnt <= fl_cnt_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .clr   (1'b0),
    .q     (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_taken),
    .clr   (1'b0),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two parameterisations driven in lockstep and
// compared each cycle against a cycle-level behavioural model.
module tb_fetch_sequencer;

  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_STEP = 2;

  localparam int A_LU = 1, A_FE = 1, A_CMAX = 65535;
  localparam int B_LU = 3, B_FE = 2, B_CMAX = 15;

  typedef struct {
    int mode;
    int owed;
    int fl_left;
    int stall_n;
    int flush_n;
  } model_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_bt = 1'b0;
  logic [7:0] in_ba = 8'h00;
  logic       in_lu = 1'b0, in_mb = 1'b0, in_hr = 1'b0, in_rs = 1'b0, in_st = 1'b0;

  logic        stall_a, flush_a, pc_sel_a, flush_id_a, halted_a;
  logic [7:0]  target_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic        stall_b, flush_b, pc_sel_b, flush_id_b, halted_b;
  logic [7:0]  target_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b;

  int n_checks = 0;
  int n_errors = 0;
  model_t m_a, m_b;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(8), .FLUSH_EXTRA(A_FE), .LU_STALL(A_LU), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .branch_taken(in_bt), .branch_addr(in_ba),
    .load_use(in_lu), .mem_busy(in_mb), .halt_req(in_hr), .resume(in_rs), .step(in_st),
    .stall(stall_a), .flush(flush_a), .PC_sel(pc_sel_a), .branch_target(target_a),
    .flush_id(flush_id_a), .halted(halted_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  fetch_sequencer #(.PC_W(8), .FLUSH_EXTRA(B_FE), .LU_STALL(B_LU), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .branch_taken(in_bt), .branch_addr(in_ba),
    .load_use(in_lu), .mem_busy(in_mb), .halt_req(in_hr), .resume(in_rs), .step(in_st),
    .stall(stall_b), .flush(flush_b), .PC_sel(pc_sel_b), .branch_target(target_b),
    .flush_id(flush_id_b), .halted(halted_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  wire [12:0] obs_a = {pc_sel_a, flush_a, flush_id_a, stall_a, halted_a, target_a};
  wire [12:0] obs_b = {pc_sel_b, flush_b, flush_id_b, stall_b, halted_b, target_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.mode = M_RUN; m.owed = 0; m.fl_left = 0; m.stall_n = 0; m.flush_n = 0;
    return m;
  endfunction

  // Fetch is held whenever debug halts it, memory is busy, or a load-use
  // hazard still owes cycles; a taken branch overrides all of these.
  function automatic logic model_stall(model_t m);
    if (in_bt) return 1'b0;
    if (in_mb) return 1'b1;
    if (m.mode == M_HALT) return 1'b1;
    if (m.mode == M_STEP) return 1'b0;
    return (m.owed > 0) || in_lu;
  endfunction

  function automatic logic [12:0] model_outs(model_t m);
    logic [7:0] tgt;
    logic       fid;
    tgt = in_bt ? in_ba : 8'h00;
    fid = in_bt || (m.fl_left > 0);
    return {in_bt, in_bt, fid, model_stall(m), (m.mode == M_HALT), tgt};
  endfunction

  function automatic model_t model_next(model_t m, int lu_len, int fe, int cmax);
    model_t n;
    n = m;
    if (model_stall(m) && n.stall_n < cmax) n.stall_n++;
    if (in_bt) begin
      if (n.flush_n < cmax) n.flush_n++;
      n.fl_left = fe;
      n.owed    = 0;
      if (m.mode == M_STEP) n.mode = M_HALT;
    end else begin
      if (n.fl_left > 0) n.fl_left--;
      if (!in_mb) begin
        if (m.mode == M_HALT) begin
          if (in_rs)      n.mode = M_RUN;
          else if (in_st) n.mode = M_STEP;
        end else if (m.mode == M_STEP) begin
          n.mode = M_HALT;
        end else if (in_hr) begin
          n.mode = M_HALT;
          n.owed = 0;
        end else if (m.owed > 0) begin
          n.owed--;
        end else if (in_lu) begin
          n.owed = lu_len - 1;
        end
      end
    end
    return n;
  endfunction

  // Called at posedge+1: apply inputs, compare mid-cycle, advance models.
  task automatic run_cycle(input logic bt, input logic [7:0] ba, input logic lu,
                           input logic mb, input logic hr, input logic rs, input logic st);
    in_bt = bt; in_ba = ba; in_lu = lu; in_mb = mb; in_hr = hr; in_rs = rs; in_st = st;
    #3;
    check("a_outs", 32'(obs_a), 32'(model_outs(m_a)));
    check("a_stall_cnt", 32'(stall_cnt_a), 32'(m_a.stall_n));
    check("a_flush_cnt", 32'(flush_cnt_a), 32'(m_a.flush_n));
    check("b_outs", 32'(obs_b), 32'(model_outs(m_b)));
    check("b_stall_cnt", 32'(stall_cnt_b), 32'(m_b.stall_n));
    check("b_flush_cnt", 32'(flush_cnt_b), 32'(m_b.flush_n));
    m_a = model_next(m_a, A_LU, A_FE, A_CMAX);
    m_b = model_next(m_b, B_LU, B_FE, B_CMAX);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_a = model_reset();
    m_b = model_reset();

    // Reset with idle inputs: everything quiet.
    #12;
    check("rst_outs_a", 32'(obs_a), 32'h0);
    check("rst_outs_b", 32'(obs_b), 32'h0);
    check("rst_cnt_a", 32'({stall_cnt_a, flush_cnt_a}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Load-use: one stall cycle on A, three on B.
    run_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("lu_len_a", 32'(stall_cnt_a), 32'd1);
    check("lu_len_b", 32'(stall_cnt_b), 32'd3);

    // Redirect to 0x3C.
    run_cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("redir_cnt_a", 32'(flush_cnt_a), 32'd1);

    // Redirect beats a same-cycle load-use: no stall follows.
    run_cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("lu_vs_br_a", 32'(stall_cnt_a), 32'd1);
    check("lu_vs_br_b", 32'(stall_cnt_b), 32'd3);

    // mem_busy for 4 cycles right after a load-use.
    run_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("busy_lu_a", 32'(stall_cnt_a), 32'd6);

    // Debug halt, single step, resume.
    run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("halt_a", 32'(halted_a), 32'd1);
    idle(2);
    run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Reset while halted returns to RUN immediately.
    run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    reset = 1'b1;
    #1;
    check("rst_halt_a", 32'({halted_a, stall_a}), 32'h0);
    check("rst_halt_b", 32'({halted_b, stall_b, stall_cnt_b}), 32'h0);
    m_a = model_reset();
    m_b = model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Random traffic; B's 4-bit counters saturate along the way.
    for (int i = 0; i < 800; i++) begin
      run_cycle(($urandom_range(0, 9) == 0), 8'($urandom),
                ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 11) == 0));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
